// File: rtl/accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_pkg
// Description : Shared constants for the accumulator memory: data width,
//               bus op codes and the one-hot FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package accumulator_pkg;

    localparam int c_data_w = 32;

    localparam logic [1:0] c_op_nop   = 2'b00;
    localparam logic [1:0] c_op_fetch = 2'b01;
    localparam logic [1:0] c_op_send  = 2'b10;

    localparam logic [3:0] c_st_idle = 4'b0001;
    localparam logic [3:0] c_st_arb  = 4'b0010;
    localparam logic [3:0] c_st_wait = 4'b0100;
    localparam logic [3:0] c_st_done = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/accumulator_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_memory_if
// Description : Processor-side bus of the accumulator memory (request, op,
//               write data, grant, completion signal and shared read data).
// Revision    : 1.0 - initial release
// ============================================================================
interface accumulator_memory_if #(
    parameter int NUM_PROC = 4
);
    logic [NUM_PROC-1:0]                        req;
    logic [2*NUM_PROC-1:0]                      op;
    logic [accumulator_pkg::c_data_w*NUM_PROC-1:0] write;
    logic [NUM_PROC-1:0]                        grant;
    logic [NUM_PROC-1:0]                        signal;
    logic [accumulator_pkg::c_data_w-1:0]       read;

    modport master (output req, op, write, input grant, signal, read);
    modport slave  (input req, op, write, output grant, signal, read);
endinterface
`default_nettype wire

// File: rtl/operand_fifo.sv
`default_nettype none
// ============================================================================
// Module      : operand_fifo
// Description : DEPTH x 32 circular operand buffer; head reads as 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fifo
    import accumulator_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [c_data_w-1:0]       push_data,
    input  logic                      pop,
    output logic [c_data_w-1:0]       head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [c_data_w-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]     r_wr_ptr;
    logic [c_aw-1:0]     r_rd_ptr;
    logic [c_aw:0]       r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/accumulator_memory.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_memory
// Description : Operand store and round-robin bus responder for the parallel
//               accumulator; flags done when only the total sum remains.
// Revision    : 1.0 - initial release
// ============================================================================
module accumulator_memory
    import accumulator_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int DEPTH    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [c_data_w-1:0]      load_data,
    input  logic                     start,
    accumulator_memory_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic [c_data_w-1:0]      result,
    output logic                     error
);
    localparam int c_ptr_w = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [3:0]            r_state;
    logic [c_ptr_w-1:0]    r_rr_ptr;
    logic [c_ptr_w-1:0]    r_cur;
    logic [c_cnt_w-1:0]    r_remaining;
    logic                  r_done;
    logic                  r_error;
    logic [NUM_PROC-1:0]   r_grant;
    logic [NUM_PROC-1:0]   r_signal;
    logic [c_data_w-1:0]   r_read;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [c_data_w-1:0]   w_push_data;
    logic [c_data_w-1:0]   w_head;
    logic [1:0]            w_cur_op;
    logic [c_data_w-1:0]   w_cur_write;
    logic [NUM_PROC-1:0]   w_elig;
    logic                  w_found;
    logic [c_ptr_w-1:0]    w_pick;

    operand_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_cur_op    = bus.op[2*int'(r_cur) +: 2];
    assign w_cur_write = bus.write[c_data_w*int'(r_cur) +: c_data_w];
    assign w_push      = ((r_state == c_st_idle) && load_en) ||
                         ((r_state == c_st_wait) && (w_cur_op == c_op_send));
    assign w_push_data = (r_state == c_st_idle) ? load_data : w_cur_write;
    assign w_pop       = (r_state == c_st_wait) && (w_cur_op == c_op_fetch) && !w_empty;

    // Fetchers parked on an empty FIFO are skipped so they cannot block senders
    always_comb begin
        w_elig  = '0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            w_elig[i] = bus.req[i] && !((bus.op[2*i +: 2] == c_op_fetch) && w_empty);
        end
        for (int k = 1; k <= NUM_PROC; k++) begin
            if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NUM_PROC]) begin
                w_found = 1'b1;
                w_pick  = c_ptr_w'((int'(r_rr_ptr) + k) % NUM_PROC);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_rr_ptr    <= '0;
            r_cur       <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_grant     <= '0;
            r_signal    <= '0;
            r_read      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (load_en && w_full) r_error <= 1'b1;
                    if (start) begin
                        r_remaining <= (count > c_cnt_w'(1)) ? count - c_cnt_w'(1) : '0;
                        r_done      <= 1'b0;
                        r_state     <= c_st_arb;
                    end
                end
                c_st_arb: begin
                    if (r_remaining == '0) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end else if (w_found) begin
                        r_grant[w_pick] <= 1'b1;
                        r_rr_ptr        <= w_pick;
                        r_cur           <= w_pick;
                        r_state         <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    case (w_cur_op)
                        c_op_fetch: begin
                            if (!w_empty) begin
                                r_read          <= w_head;
                                r_signal[r_cur] <= 1'b1;
                                r_state         <= c_st_done;
                            end else begin
                                r_grant[r_cur]  <= 1'b0;
                                r_state         <= c_st_arb;
                            end
                        end
                        c_op_send: begin
                            if (w_full) r_error <= 1'b1;
                            r_remaining     <= r_remaining - 1'b1;
                            r_signal[r_cur] <= 1'b1;
                            r_state         <= c_st_done;
                        end
                        default: r_state <= c_st_wait;
                    endcase
                end
                c_st_done: begin
                    r_signal <= '0;
                    r_grant  <= '0;
                    r_state  <= c_st_arb;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.grant  = r_grant;
    assign bus.signal = r_signal;
    assign bus.read   = r_read;
    assign done       = r_done;
    assign error      = r_error;
    assign result     = w_head;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_accumulator_memory
// Description : Directed self-checking bench with bus-level processor models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulator_memory;
    import accumulator_pkg::*;

    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en, start;
    logic [31:0] load_data;
    logic [6:0]  count;
    logic        done, error;
    logic [31:0] result;

    logic        load_en4;
    logic [31:0] load_data4;
    logic        start4;
    logic [2:0]  count4;
    logic        done4, error4;
    logic [31:0] result4;

    accumulator_memory_if #(.NUM_PROC(NP)) bus ();
    accumulator_memory_if #(.NUM_PROC(NP)) bus4 ();

    accumulator_memory #(.NUM_PROC(NP), .DEPTH(64)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
        .start(start), .bus(bus), .count(count), .done(done),
        .result(result), .error(error)
    );

    accumulator_memory #(.NUM_PROC(NP), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .load_en(load_en4), .load_data(load_data4),
        .start(start4), .bus(bus4), .count(count4), .done(done4),
        .result(result4), .error(error4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int claimed, n_fetch, n_send, sig2_cnt;
    int order[$];
    logic [NP-1:0] prev_grant;
    logic rec_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.signal[2]) sig2_cnt++;
        if (rec_on && bus.grant != '0 && bus.grant != prev_grant) begin
            for (int i = 0; i < NP; i++) if (bus.grant[i]) order.push_back(i);
        end
        prev_grant = bus.grant;
    end

    // Processor bus transaction: request with NOP, present op once granted
    task automatic xfer(input int p, input logic [1:0] o, input logic [31:0] wd,
                        output logic [31:0] rd);
        logic ok = 1'b0;
        rd = '0;
        @(negedge clk);
        bus.req[p] = 1'b1;
        bus.op[2*p +: 2] = c_op_nop;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (bus.grant[p] && bus.signal[p]) begin
                rd = bus.read;
                ok = 1'b1;
                break;
            end
            if (bus.grant[p]) begin
                bus.op[2*p +: 2]    = o;
                bus.write[32*p +: 32] = wd;
            end
        end
        if (!ok) check("xfer_timeout", {31'b0, ok}, 32'd1);
        else if (o == c_op_fetch) n_fetch++;
        else if (o == c_op_send) n_send++;
        bus.req[p] = 1'b0;
        bus.op[2*p +: 2] = c_op_nop;
    endtask

    // Claims two operands before starting a job so all ports can never park at once
    task automatic proc(input int p);
        logic [31:0] a, b, d;
        int guard = 0;
        while (!done && guard < 3000) begin
            if (int'(count) - claimed >= 2) begin
                claimed += 2;
                xfer(p, c_op_fetch, 0, a); claimed--;
                xfer(p, c_op_fetch, 0, b); claimed--;
                xfer(p, c_op_send, a + b, d);
            end else begin
                @(negedge clk);
                guard++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic load1(input logic [31:0] v);
        @(negedge clk); load_en = 1'b1; load_data = v;
        @(negedge clk); load_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 50 && !done; c++) @(negedge clk);
        check(tag, {31'b0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd2;
        int s0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        reset = 1'b1; load_en = 1'b0; load_data = '0; start = 1'b0;
        load_en4 = 1'b0; load_data4 = '0; start4 = 1'b0;
        bus.req = '0; bus.op = '0; bus.write = '0;
        bus4.req = '0; bus4.op = '0; bus4.write = '0;
        rec_on = 1'b0; prev_grant = '0; sig2_cnt = 0;
        n_fetch = 0; n_send = 0; claimed = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_grant",  {28'b0, bus.grant}, 0);
        check("rst_signal", {28'b0, bus.signal}, 0);
        check("rst_read",   bus.read, 0);
        check("rst_count",  {25'b0, count}, 0);
        check("rst_done",   {31'b0, done}, 0);
        check("rst_result", result, 0);
        check("rst_error",  {31'b0, error}, 0);

        // start on empty FIFO, then with a single operand
        pulse_start();
        check("empty_done_e1", {31'b0, done}, 0);
        @(negedge clk);
        check("empty_done_e2", {31'b0, done}, 1);
        check("empty_result", result, 0);
        load1(32'd42);
        pulse_start();
        check("one_done_e1", {31'b0, done}, 0);
        @(negedge clk);
        check("one_done_e2", {31'b0, done}, 1);
        check("one_result", result, 42);

        // single processor: 3 + 5
        do_reset();
        load1(32'd3); load1(32'd5);
        pulse_start();
        xfer(0, c_op_fetch, 0, rd); check("t1_read_a", rd, 3);
        xfer(0, c_op_fetch, 0, rd); check("t1_read_b", rd, 5);
        xfer(0, c_op_send, 32'd8, rd);
        wait_done("t1_done");
        check("t1_result", result, 8);
        check("t1_count", {25'b0, count}, 1);
        check("t1_error", {31'b0, error}, 0);

        // four processors summing 1..16
        do_reset();
        for (int v = 1; v <= 16; v++) load1(32'(v));
        pulse_start();
        n_fetch = 0; n_send = 0; claimed = 0;
        fork
            proc(0); proc(1); proc(2); proc(3);
        join
        wait_done("t2_done");
        check("t2_result", result, 136);
        check("t2_sends", 32'(n_send), 15);
        check("t2_fetches", 32'(n_fetch), 30);
        check("t2_count", {25'b0, count}, 1);

        // parked fetcher on empty FIFO
        do_reset();
        load1(32'd10); load1(32'd20); load1(32'd30);
        pulse_start();
        xfer(0, c_op_fetch, 0, rd);
        xfer(0, c_op_fetch, 0, rd);
        xfer(0, c_op_fetch, 0, rd); check("park_pre_read", rd, 30);
        s0 = sig2_cnt;
        fork
            xfer(2, c_op_fetch, 0, rd2);
            begin
                for (int c = 0; c < 50 && !bus.grant[2]; c++) @(negedge clk);
                check("park_granted", {31'b0, bus.grant[2]}, 1);
                repeat (3) @(negedge clk);
                check("park_drop", {31'b0, bus.grant[2]}, 0);
                repeat (5) @(negedge clk);
                check("park_hold", {31'b0, bus.grant[2]}, 0);
                check("park_no_signal", 32'(sig2_cnt - s0), 0);
                xfer(1, c_op_send, 32'd7, rd);
            end
        join
        check("park_read", rd2, 7);
        xfer(3, c_op_send, 32'd67, rd);
        wait_done("park_done");
        check("park_result", result, 67);

        // round robin from rr_ptr=3 (port 3 was last granted)
        for (int v = 1; v <= 5; v++) load1(32'(v));
        pulse_start();
        order.delete();
        rec_on = 1'b1;
        fork
            begin xfer(0, c_op_send, 32'd100, rd); xfer(0, c_op_send, 32'd200, rd); end
            xfer(1, c_op_send, 32'd101, rd2);
            begin logic [31:0] t; xfer(2, c_op_send, 32'd102, t); end
            begin logic [31:0] t; xfer(3, c_op_send, 32'd103, t); end
        join
        rec_on = 1'b0;
        wait_done("rr_done");
        check("rr_len", 32'(order.size()), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'd99,
                  32'(exp_order[i]));
        check("rr_result", result, 67);
        check("rr_count", {25'b0, count}, 11);

        // reset while a grant is held in WAIT
        do_reset();
        load1(32'd1); load1(32'd2);
        pulse_start();
        @(negedge clk); bus.req[1] = 1'b1; bus.op[3:2] = c_op_nop;
        for (int c = 0; c < 50 && !bus.grant[1]; c++) @(negedge clk);
        check("wait_grant", {28'b0, bus.grant}, 32'b0010);
        repeat (2) @(negedge clk);
        check("wait_nop_hold", {28'b0, bus.grant}, 32'b0010);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.req[1] = 1'b0;
        check("mid_rst_grant",  {28'b0, bus.grant}, 0);
        check("mid_rst_signal", {28'b0, bus.signal}, 0);
        check("mid_rst_count",  {25'b0, count}, 0);
        check("mid_rst_done",   {31'b0, done}, 0);
        load1(32'd9);
        check("mid_rst_idle_load", {25'b0, count}, 1);

        // overflow on a 4-deep instance
        for (int v = 0; v < 5; v++) begin
            @(negedge clk); load_en4 = 1'b1; load_data4 = 32'(11 + v);
            @(negedge clk); load_en4 = 1'b0;
            if (v == 3) begin
                check("ovf_count4_pre", {29'b0, count4}, 4);
                check("ovf_error_pre", {31'b0, error4}, 0);
            end
        end
        check("ovf_count4", {29'b0, count4}, 4);
        check("ovf_error", {31'b0, error4}, 1);
        check("ovf_head", result4, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accumulator_memory.md
# accumulator_memory

Shared operand store and bus responder for the parallel accumulator. It holds a FIFO of 32-bit operands, arbitrates up to NUM_PROC accumulator processors, and serves their FETCH requests (pop an operand) and SEND requests (push a partial sum). It asserts `done` when exactly one value, the total sum, remains.

## Interface
- NUM_PROC, 4, number of processor ports (≥2)
- DEPTH, 64, operand FIFO entries (power of two)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- load_en  in  1  push `load_data` while idle
- load_data  in  32  initial operand
- start  in  1  one-cycle pulse that begins accumulation
- req  in  NUM_PROC  per-processor bus request
- op  in  2*NUM_PROC  per-processor op; port i is op[2i+1:2i]; NOP=00, FETCH=01, SEND=10
- write  in  32*NUM_PROC  per-processor result; port i is write[32i+31:32i]
- grant  out  NUM_PROC  one-hot bus grant
- signal  out  NUM_PROC  per-port completion pulse
- read  out  32  fetched operand, shared
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- done  out  1  accumulation complete, sticky
- result  out  32  FIFO head, valid while `done`
- error  out  1  sticky overflow error

## Operation
- Reset value of every output is 0. Reset clears the FIFO, the round-robin pointer, the remaining counter and the state, and returns the block to IDLE.
- **IDLE**
  - `load_en` pushes `load_data`. A push while full is dropped and sets `error`.
  - `start` latches remaining = count−1 (0 if count ≤ 1), clears `done`, then goes to ARB.
- **ARB**
  - If remaining==0: set `done`, go to IDLE.
  - Otherwise pick the first eligible port at or after rr_ptr+1, modulo NUM_PROC.
  - A port is eligible when req[i]=1 and not (op_i==FETCH and count==0), i.e. parked fetchers are skipped.
  - On a pick: grant[i]<=1, rr_ptr<=i, go to WAIT. With no eligible port, stay in ARB.
- **WAIT** (grant[i] held)
  - op_i==NOP: stay.
  - FETCH with count>0: read<=head, pop, signal[i]<=1, go to DONE.
  - FETCH with count==0: grant[i]<=0, go to ARB. The processor stays parked with req and op=FETCH held.
  - SEND: push write_i, remaining<=remaining−1, signal[i]<=1, go to DONE. If the FIFO is full, drop the data and set `error`.
  - op==11: treated as NOP.
- **DONE**: signal[i]<=0, grant[i]<=0, go to ARB.
- Once `done` is set, no further grants are issued until the next `start`.
- `result` = FIFO head. Sums are modulo 2^32; no carry or overflow flag is kept.

## Timing
- Grant is asserted one cycle after ARB sees a request.
- The processor registers op, so op appears ≥1 cycle after grant.
- `signal` and `read` assert together at the edge after op is seen, and hold exactly 1 cycle. The processor samples `read` at the edge where signal=1.
- Grant and signal drop together. The next cycle (ARB) is guaranteed to have grant=0 and signal=0, so a requester's grant && !signal check never sees a stale signal.
- Minimum transaction: grant edge, op edge, signal edge, release edge, i.e. 4 cycles per transfer, one transfer at a time.
- Pop and push in the same cycle cannot occur, since transfers are serialized.
- `start` outside IDLE is ignored. `load_en` outside IDLE is ignored.
- With count==1 at `start`: `done` at the second edge after `start`, result = that operand.
- With count==0 at `start`: `done` at the second edge after `start`, result = 0.

## Structure
- Package accumulator_pkg holds:
  - op codes NOP/FETCH/SEND
  - the IDLE/ARB/WAIT/DONE state encoding, one-hot
  - the 32-bit data width constant
- Sub-module operand_fifo:
  - DEPTH×32 circular buffer
  - push, pop, head, count, full, empty
  - pointers wrap modulo DEPTH
- Top level holds the arbiter, the FSM, the remaining counter and the error/done flags.

## Test plan
- Load 3, 5; start; one processor model does FETCH, FETCH, SEND 8 → done=1, result=8, count=1, error=0.
- Load 1..16; start; 4 processor models → done=1, result=136, exactly 15 SENDs, 30 FETCH signals.
- Round-robin: all 4 req high, rr_ptr=3 → grant order 0,1,2,3,0; no port starved.
- Park: count=0, port 2 FETCHes → grant[2] drops with no signal; port 1 SENDs 7 → port 2 regranted and gets read=7.
- DEPTH=4, load 5 values → 5th dropped, error=1, count=4.
- Reset mid-WAIT with grant[1]=1 → next edge grant=0, signal=0, count=0, done=0, state IDLE.
